// File: rtl/syn_sram_acc_arb.sv
`timescale 1ns/1ps
//----------------------------------------------------------------------------
// syn_sram_acc_arb
//
// Purpose:
//   Owns the pins of the external asynchronous frame-buffer SRAM and
//   arbitrates single-word accesses between two requestors:
//     - GPU pixel gateway (read/write)
//     - VGA frame fetch   (read-only)
//   VGA has priority, but once VGA_BURST_MAX VGA grants have been made while
//   the GPU is waiting, the next eligible GPU request wins. A write followed
//   by a read (or by any VGA access) gets one IDLE pin cycle so the data bus
//   can turn around. Read data returns two cycles after acceptance.
//
// Ports:
//   clk_ir, rst_il          clock, asynchronous active-low reset
//   gpu_req/wr/addr/wdata   GPU request (held until gpu_ready)
//   gpu_ready               GPU accepted this cycle (combinational)
//   gpu_rd_valid/rdata      GPU read return (1-cycle pulse, data held)
//   vga_req/addr            VGA read request (held until vga_ready)
//   vga_ready               VGA accepted this cycle (combinational)
//   vga_rd_valid/rdata      VGA read return (1-cycle pulse, data held)
//   sram_addr, sram_dq_o    registered SRAM address / write data
//   sram_dq_oe              registered data-bus output enable (active-high)
//   sram_dq_i               SRAM data bus input
//   sram_ce_n/oe_n/we_n     registered SRAM strobes (active-low)
//----------------------------------------------------------------------------
module syn_sram_acc_arb #(
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16,
    parameter int VGA_BURST_MAX = 8
) (
    input  logic              clk_ir,
    input  logic              rst_il,
    // GPU pixel gateway
    input  logic              gpu_req,
    input  logic              gpu_wr,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [DATA_W-1:0] gpu_wdata,
    output logic              gpu_ready,
    output logic              gpu_rd_valid,
    output logic [DATA_W-1:0] gpu_rdata,
    // VGA frame fetch
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ready,
    output logic              vga_rd_valid,
    output logic [DATA_W-1:0] vga_rdata,
    // SRAM pins
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    // Keep the burst limit inside the 8-bit run counter's useful range.
    localparam int BURST_CLAMP =
        (VGA_BURST_MAX < 1)   ? 1   :
        (VGA_BURST_MAX > 255) ? 255 : VGA_BURST_MAX;
    localparam logic [7:0] BURST_MAX_C = 8'(BURST_CLAMP);

    // Pin activity of the current cycle.
    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_RD   = 2'd1,
        PS_WR   = 2'd2
    } ps_t;

    ps_t               r_ps;
    logic [7:0]        r_vga_run_cnt;
    logic              r_rd_tag_gpu;     // owner of the read on the pins now
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_dq_o;
    logic              r_sram_dq_oe;
    logic              r_sram_ce_n;
    logic              r_sram_oe_n;
    logic              r_sram_we_n;
    logic              r_gpu_rd_valid;
    logic              r_vga_rd_valid;
    logic [DATA_W-1:0] r_gpu_rdata;
    logic [DATA_W-1:0] r_vga_rdata;

    logic w_vga_elig;
    logic w_gpu_elig;
    logic w_starved;
    logic w_gpu_grant;
    logic w_vga_grant;
    logic w_rd_cycle;

    //------------------------------------------------------------------------
    // Eligibility and priority
    //------------------------------------------------------------------------
    always_comb begin
        // While a write is on the pins only another GPU write may follow, and
        // only when VGA is not asking; anything else waits one bubble cycle so
        // the bus is never driven by both sides.
        w_vga_elig  = vga_req && (r_ps != PS_WR);
        w_gpu_elig  = gpu_req && ((r_ps != PS_WR) || (gpu_wr && !vga_req));
        w_starved   = (r_vga_run_cnt == BURST_MAX_C);
        w_gpu_grant = w_gpu_elig && (!w_vga_elig || w_starved);
        w_vga_grant = w_vga_elig && !w_gpu_grant;
    end

    // Readies are held low while reset is asserted.
    assign gpu_ready  = w_gpu_grant && rst_il;
    assign vga_ready  = w_vga_grant && rst_il;
    assign w_rd_cycle = (r_ps == PS_RD);

    //------------------------------------------------------------------------
    // Pin-state machine: the state and every SRAM pin are registered
    // together from the grant decision of the previous cycle.
    //------------------------------------------------------------------------
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            r_ps         <= PS_IDLE;
            r_rd_tag_gpu <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_dq_o  <= '0;
            r_sram_dq_oe <= 1'b0;
            r_sram_ce_n  <= 1'b1;
            r_sram_oe_n  <= 1'b1;
            r_sram_we_n  <= 1'b1;
        end else begin
            // Default: IDLE strobes; address and write data hold.
            r_ps         <= PS_IDLE;
            r_sram_dq_oe <= 1'b0;
            r_sram_ce_n  <= 1'b1;
            r_sram_oe_n  <= 1'b1;
            r_sram_we_n  <= 1'b1;
            if (w_gpu_grant) begin
                r_sram_addr <= gpu_addr;
                r_sram_ce_n <= 1'b0;
                if (gpu_wr) begin
                    r_ps         <= PS_WR;
                    r_sram_dq_o  <= gpu_wdata;
                    r_sram_dq_oe <= 1'b1;
                    r_sram_we_n  <= 1'b0;
                end else begin
                    r_ps         <= PS_RD;
                    r_sram_oe_n  <= 1'b0;
                    r_rd_tag_gpu <= 1'b1;
                end
            end else if (w_vga_grant) begin
                r_ps         <= PS_RD;
                r_sram_addr  <= vga_addr;
                r_sram_ce_n  <= 1'b0;
                r_sram_oe_n  <= 1'b0;
                r_rd_tag_gpu <= 1'b0;
            end
        end
    end

    //------------------------------------------------------------------------
    // VGA run counter: counts VGA grants made while the GPU is waiting.
    //------------------------------------------------------------------------
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            r_vga_run_cnt <= 8'd0;
        end else if (!gpu_req || w_gpu_grant) begin
            r_vga_run_cnt <= 8'd0;
        end else if (w_vga_grant && (r_vga_run_cnt != BURST_MAX_C)) begin
            r_vga_run_cnt <= r_vga_run_cnt + 8'd1;
        end
    end

    //------------------------------------------------------------------------
    // Read return: sample the bus at the end of the RD cycle into the
    // tagged agent's data register and pulse its valid one cycle later.
    // Reset clears the RD state, so a read in flight at reset never returns.
    //------------------------------------------------------------------------
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            r_gpu_rd_valid <= 1'b0;
            r_vga_rd_valid <= 1'b0;
            r_gpu_rdata    <= '0;
            r_vga_rdata    <= '0;
        end else begin
            r_gpu_rd_valid <= w_rd_cycle && r_rd_tag_gpu;
            r_vga_rd_valid <= w_rd_cycle && !r_rd_tag_gpu;
            if (w_rd_cycle && r_rd_tag_gpu) begin
                r_gpu_rdata <= sram_dq_i;
            end
            if (w_rd_cycle && !r_rd_tag_gpu) begin
                r_vga_rdata <= sram_dq_i;
            end
        end
    end

    assign sram_addr    = r_sram_addr;
    assign sram_dq_o    = r_sram_dq_o;
    assign sram_dq_oe   = r_sram_dq_oe;
    assign sram_ce_n    = r_sram_ce_n;
    assign sram_oe_n    = r_sram_oe_n;
    assign sram_we_n    = r_sram_we_n;
    assign gpu_rd_valid = r_gpu_rd_valid;
    assign gpu_rdata    = r_gpu_rdata;
    assign vga_rd_valid = r_vga_rd_valid;
    assign vga_rdata    = r_vga_rdata;

endmodule

// File: tb/tb_syn_sram_acc_arb.sv
`timescale 1ns/1ps
//----------------------------------------------------------------------------
// tb_syn_sram_acc_arb
//
// Purpose: self-checking bench for syn_sram_acc_arb. Contains a behavioural
// asynchronous SRAM, a table of directed vectors, hand-written sequences for
// VGA-burst starvation and mid-read reset, and a randomized run checked
// against a transaction-level reference model.
//----------------------------------------------------------------------------
module tb_syn_sram_acc_arb;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int BURST  = 8;

    localparam logic [3:0] P_ID = 4'b1110;  // {ce_n, oe_n, we_n, dq_oe}
    localparam logic [3:0] P_RD = 4'b0010;
    localparam logic [3:0] P_WR = 4'b0101;

    logic              clk_ir = 1'b0;
    logic              rst_il = 1'b0;
    logic              gpu_req = 1'b0;
    logic              gpu_wr = 1'b0;
    logic [ADDR_W-1:0] gpu_addr = '0;
    logic [DATA_W-1:0] gpu_wdata = '0;
    logic              gpu_ready;
    logic              gpu_rd_valid;
    logic [DATA_W-1:0] gpu_rdata;
    logic              vga_req = 1'b0;
    logic [ADDR_W-1:0] vga_addr = '0;
    logic              vga_ready;
    logic              vga_rd_valid;
    logic [DATA_W-1:0] vga_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_o;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_i;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_ir = ~clk_ir;

    syn_sram_acc_arb #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .VGA_BURST_MAX (BURST)
    ) dut (
        .clk_ir       (clk_ir),
        .rst_il       (rst_il),
        .gpu_req      (gpu_req),
        .gpu_wr       (gpu_wr),
        .gpu_addr     (gpu_addr),
        .gpu_wdata    (gpu_wdata),
        .gpu_ready    (gpu_ready),
        .gpu_rd_valid (gpu_rd_valid),
        .gpu_rdata    (gpu_rdata),
        .vga_req      (vga_req),
        .vga_addr     (vga_addr),
        .vga_ready    (vga_ready),
        .vga_rd_valid (vga_rd_valid),
        .vga_rdata    (vga_rdata),
        .sram_addr    (sram_addr),
        .sram_dq_o    (sram_dq_o),
        .sram_dq_oe   (sram_dq_oe),
        .sram_dq_i    (sram_dq_i),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n)
    );

    function automatic logic [15:0] init_word(input int a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    //------------------------------------------------------------------------
    // Asynchronous SRAM model (1K words, address aliased on the low 10 bits)
    //------------------------------------------------------------------------
    logic [15:0] sram_mem [0:1023];
    logic        mem_clear = 1'b0;

    always @(posedge clk_ir) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= init_word(i);
        end else if (!sram_ce_n && !sram_we_n) begin
            sram_mem[sram_addr[9:0]] <= sram_dq_o;
        end
    end

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 16'h0000;

    // Bus-contention monitor: write and output strobes never low together.
    always @(negedge clk_ir) begin
        if (rst_il) begin
            n_vec++;
            if (!sram_we_n && !sram_oe_n) begin
                n_miss++;
                $display("FAIL strobe_conflict: got we_n=%b oe_n=%b, required not both 0", sram_we_n, sram_oe_n);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] pins_of(input int op);
        case (op)
            1:       return P_RD;
            2:       return P_WR;
            default: return P_ID;
        endcase
    endfunction

    task automatic do_reset();
        rst_il    = 1'b0;
        gpu_req   = 1'b0;
        vga_req   = 1'b0;
        mem_clear = 1'b1;
        @(posedge clk_ir); #1;
        @(posedge clk_ir); #1;
        mem_clear = 1'b0;
        @(negedge clk_ir);
        rst_il = 1'b1;
        @(posedge clk_ir); #1;
    endtask

    //------------------------------------------------------------------------
    // Directed vector table
    //------------------------------------------------------------------------
    typedef struct {
        logic        g_req;
        logic        g_wr;
        logic [17:0] g_addr;
        logic [15:0] g_wdata;
        logic        v_req;
        logic [17:0] v_addr;
        logic        e_gr;
        logic        e_vr;
        logic [3:0]  e_pins;
        logic [17:0] e_saddr;
        logic [15:0] e_dq;
        logic        e_grv;
        logic        e_vrv;
        logic [15:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic gr, input logic gw, input logic [17:0] ga, input logic [15:0] gd,
        input logic vr, input logic [17:0] va,
        input logic egr, input logic evr, input logic [3:0] ep, input logic [17:0] ea,
        input logic [15:0] ed, input logic egv, input logic evv, input logic [15:0] erd);
        vec_t v;
        v.g_req = gr; v.g_wr = gw; v.g_addr = ga; v.g_wdata = gd;
        v.v_req = vr; v.v_addr = va;
        v.e_gr = egr; v.e_vr = evr; v.e_pins = ep; v.e_saddr = ea; v.e_dq = ed;
        v.e_grv = egv; v.e_vrv = evv; v.e_rdata = erd;
        return v;
    endfunction

    localparam int NV = 17;
    vec_t vecs [NV];

    // Reference-model state for the randomized run
    typedef struct {
        logic        gpu;
        logic [15:0] data;
        int          due;
    } ret_t;
    ret_t        ret_q [$];
    logic [15:0] shadow [0:1023];

    initial begin
        logic        g_pend, v_pend, v_el, g_el, g_win, v_win, exp_grv, exp_vrv;
        logic [15:0] exp_g_rd, exp_v_rd;
        logic [17:0] exp_addr;
        int          prev_op, op, streak, vg, rv_cnt;
        bit          exp_g;
        ret_t        r;

        // Accepted in cycle k; pins and read returns checked after edge k.
        vecs[0]  = mk(1'b0,1'b0,18'h0,16'h0,      1'b0,18'h0,   1'b0,1'b0,P_ID,18'h0,  16'h0,     1'b0,1'b0,16'h0);
        vecs[1]  = mk(1'b1,1'b1,18'h10,16'hBEEF,  1'b0,18'h0,   1'b1,1'b0,P_WR,18'h10, 16'hBEEF,  1'b0,1'b0,16'h0);
        vecs[2]  = mk(1'b1,1'b0,18'h10,16'h0,     1'b0,18'h0,   1'b0,1'b0,P_ID,18'h10, 16'h0,     1'b0,1'b0,16'h0);
        vecs[3]  = mk(1'b1,1'b0,18'h10,16'h0,     1'b0,18'h0,   1'b1,1'b0,P_RD,18'h10, 16'h0,     1'b0,1'b0,16'h0);
        vecs[4]  = mk(1'b0,1'b0,18'h0,16'h0,      1'b0,18'h0,   1'b0,1'b0,P_ID,18'h10, 16'h0,     1'b1,1'b0,16'hBEEF);
        vecs[5]  = mk(1'b1,1'b1,18'h20,16'h1234,  1'b1,18'h100, 1'b0,1'b1,P_RD,18'h100,16'h0,     1'b0,1'b0,16'h0);
        vecs[6]  = mk(1'b1,1'b1,18'h20,16'h1234,  1'b1,18'h101, 1'b0,1'b1,P_RD,18'h101,16'h0,     1'b0,1'b1,init_word(32'h100));
        vecs[7]  = mk(1'b1,1'b1,18'h20,16'h1234,  1'b0,18'h0,   1'b1,1'b0,P_WR,18'h20, 16'h1234,  1'b0,1'b1,init_word(32'h101));
        vecs[8]  = mk(1'b1,1'b1,18'h21,16'h5678,  1'b1,18'h102, 1'b0,1'b0,P_ID,18'h20, 16'h0,     1'b0,1'b0,16'h0);
        vecs[9]  = mk(1'b1,1'b1,18'h21,16'h5678,  1'b1,18'h102, 1'b0,1'b1,P_RD,18'h102,16'h0,     1'b0,1'b0,16'h0);
        vecs[10] = mk(1'b1,1'b1,18'h21,16'h5678,  1'b0,18'h0,   1'b1,1'b0,P_WR,18'h21, 16'h5678,  1'b0,1'b1,init_word(32'h102));
        vecs[11] = mk(1'b1,1'b1,18'h22,16'h0022,  1'b0,18'h0,   1'b1,1'b0,P_WR,18'h22, 16'h0022,  1'b0,1'b0,16'h0);
        vecs[12] = mk(1'b1,1'b1,18'h23,16'h0023,  1'b0,18'h0,   1'b1,1'b0,P_WR,18'h23, 16'h0023,  1'b0,1'b0,16'h0);
        vecs[13] = mk(1'b1,1'b1,18'h24,16'h0024,  1'b0,18'h0,   1'b1,1'b0,P_WR,18'h24, 16'h0024,  1'b0,1'b0,16'h0);
        vecs[14] = mk(1'b0,1'b0,18'h0,16'h0,      1'b0,18'h0,   1'b0,1'b0,P_ID,18'h24, 16'h0,     1'b0,1'b0,16'h0);
        vecs[15] = mk(1'b1,1'b0,18'h21,16'h0,     1'b0,18'h0,   1'b1,1'b0,P_RD,18'h21, 16'h0,     1'b0,1'b0,16'h0);
        vecs[16] = mk(1'b0,1'b0,18'h0,16'h0,      1'b0,18'h0,   1'b0,1'b0,P_ID,18'h21, 16'h0,     1'b1,1'b0,16'h5678);

        //--------------------------------------------------------------------
        // Reset state (checked while reset is held, with a request pending)
        //--------------------------------------------------------------------
        rst_il = 1'b0;
        mem_clear = 1'b1;
        @(posedge clk_ir); #1;
        @(posedge clk_ir); #1;
        mem_clear = 1'b0;
        vga_req = 1'b1;
        gpu_req = 1'b1;
        #1;
        chk("reset_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'(P_ID));
        chk("reset_addr", 32'(sram_addr), 32'h0);
        chk("reset_dq_o", 32'(sram_dq_o), 32'h0);
        chk("reset_readies", 32'({gpu_ready, vga_ready}), 32'h0);
        chk("reset_rd_valid", 32'({gpu_rd_valid, vga_rd_valid}), 32'h0);
        chk("reset_rdata", 32'({gpu_rdata, vga_rdata}), 32'h0);
        vga_req = 1'b0;
        gpu_req = 1'b0;
        @(negedge clk_ir);
        rst_il = 1'b1;
        @(posedge clk_ir); #1;

        //--------------------------------------------------------------------
        // Directed table
        //--------------------------------------------------------------------
        for (int k = 0; k < NV; k++) begin
            gpu_req   = vecs[k].g_req;
            gpu_wr    = vecs[k].g_wr;
            gpu_addr  = vecs[k].g_addr;
            gpu_wdata = vecs[k].g_wdata;
            vga_req   = vecs[k].v_req;
            vga_addr  = vecs[k].v_addr;
            @(negedge clk_ir);
            chk($sformatf("vec%0d gpu_ready", k), 32'(gpu_ready), 32'(vecs[k].e_gr));
            chk($sformatf("vec%0d vga_ready", k), 32'(vga_ready), 32'(vecs[k].e_vr));
            @(posedge clk_ir); #1;
            chk($sformatf("vec%0d pins", k), 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'(vecs[k].e_pins));
            chk($sformatf("vec%0d sram_addr", k), 32'(sram_addr), 32'(vecs[k].e_saddr));
            if (vecs[k].e_pins == P_WR)
                chk($sformatf("vec%0d sram_dq_o", k), 32'(sram_dq_o), 32'(vecs[k].e_dq));
            chk($sformatf("vec%0d gpu_rd_valid", k), 32'(gpu_rd_valid), 32'(vecs[k].e_grv));
            chk($sformatf("vec%0d vga_rd_valid", k), 32'(vga_rd_valid), 32'(vecs[k].e_vrv));
            if (vecs[k].e_grv) chk($sformatf("vec%0d gpu_rdata", k), 32'(gpu_rdata), 32'(vecs[k].e_rdata));
            if (vecs[k].e_vrv) chk($sformatf("vec%0d vga_rdata", k), 32'(vga_rdata), 32'(vecs[k].e_rdata));
            $display("vec %0d: gready=%0b vready=%0b pins=%b addr=%h", k, vecs[k].e_gr, vecs[k].e_vr,
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, sram_addr);
        end

        //--------------------------------------------------------------------
        // Starvation bound: continuous VGA and GPU read requests
        //--------------------------------------------------------------------
        do_reset();
        gpu_req  = 1'b1;
        gpu_wr   = 1'b0;
        gpu_addr = 18'h200;
        vga_req  = 1'b1;
        vga_addr = 18'h100;
        vg = 0;
        rv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            exp_g = (i % 9 == 8);
            @(negedge clk_ir);
            chk($sformatf("burst%0d gpu_ready", i), 32'(gpu_ready), 32'(exp_g));
            chk($sformatf("burst%0d vga_ready", i), 32'(vga_ready), 32'(!exp_g));
            @(posedge clk_ir); #1;
            if (vga_rd_valid) begin
                chk($sformatf("burst vga_rdata#%0d", rv_cnt), 32'(vga_rdata), 32'(init_word(32'h100 + rv_cnt)));
                rv_cnt++;
            end
            $display("burst cycle %0d: grant to %s", i, exp_g ? "gpu" : "vga");
            if (exp_g) gpu_addr = gpu_addr + 18'd1;
            else begin
                vg++;
                vga_addr = vga_addr + 18'd1;
            end
        end
        gpu_req = 1'b0;
        vga_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_ir); #1;
            if (vga_rd_valid) begin
                chk($sformatf("burst vga_rdata#%0d", rv_cnt), 32'(vga_rdata), 32'(init_word(32'h100 + rv_cnt)));
                rv_cnt++;
            end
        end
        chk("burst vga_rd_valid count", 32'(rv_cnt), 32'(18));

        //--------------------------------------------------------------------
        // Randomized run against the transaction-level model
        //--------------------------------------------------------------------
        do_reset();
        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
        ret_q.delete();
        prev_op = 0;
        streak = 0;
        g_pend = 1'b0;
        v_pend = 1'b0;
        exp_g_rd = 16'h0;
        exp_v_rd = 16'h0;
        for (int c = 0; c < 300; c++) begin
            if (!g_pend && ($urandom_range(0, 2) != 0)) begin
                g_pend    = 1'b1;
                gpu_wr    = 1'($urandom_range(0, 1));
                gpu_addr  = 18'($urandom_range(0, 63));
                gpu_wdata = 16'($urandom);
            end
            if (!v_pend && ($urandom_range(0, 3) != 0)) begin
                v_pend   = 1'b1;
                vga_addr = 18'($urandom_range(0, 63));
            end
            gpu_req = g_pend;
            vga_req = v_pend;

            // After a write only a GPU write with VGA idle may go next;
            // VGA wins unless it has run BURST times against a waiting GPU.
            v_el  = vga_req && (prev_op != 2);
            g_el  = gpu_req && ((prev_op != 2) || (gpu_wr && !vga_req));
            g_win = g_el && (!v_el || (streak >= BURST));
            v_win = v_el && !g_win;
            op = g_win ? (gpu_wr ? 2 : 1) : (v_win ? 1 : 0);
            exp_addr = g_win ? gpu_addr : vga_addr;

            @(negedge clk_ir);
            chk($sformatf("rand%0d gpu_ready", c), 32'(gpu_ready), 32'(g_win));
            chk($sformatf("rand%0d vga_ready", c), 32'(vga_ready), 32'(v_win));
            @(posedge clk_ir); #1;
            chk($sformatf("rand%0d pins", c), 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'(pins_of(op)));
            if (op != 0) chk($sformatf("rand%0d sram_addr", c), 32'(sram_addr), 32'(exp_addr));
            if (op == 2) chk($sformatf("rand%0d sram_dq_o", c), 32'(sram_dq_o), 32'(gpu_wdata));

            exp_grv = 1'b0;
            exp_vrv = 1'b0;
            if ((ret_q.size() > 0) && (ret_q[0].due == c)) begin
                r = ret_q.pop_front();
                if (r.gpu) begin
                    exp_grv = 1'b1;
                    exp_g_rd = r.data;
                end else begin
                    exp_vrv = 1'b1;
                    exp_v_rd = r.data;
                end
            end
            chk($sformatf("rand%0d gpu_rd_valid", c), 32'(gpu_rd_valid), 32'(exp_grv));
            chk($sformatf("rand%0d vga_rd_valid", c), 32'(vga_rd_valid), 32'(exp_vrv));
            chk($sformatf("rand%0d gpu_rdata", c), 32'(gpu_rdata), 32'(exp_g_rd));
            chk($sformatf("rand%0d vga_rdata", c), 32'(vga_rdata), 32'(exp_v_rd));

            if (op == 1) begin
                r.gpu  = g_win;
                r.data = shadow[exp_addr[9:0]];
                r.due  = c + 1;
                ret_q.push_back(r);
            end
            if (op == 2) shadow[gpu_addr[9:0]] = gpu_wdata;
            if (op != 0)
                $display("rand cycle %0d: %s %s addr=%h", c, g_win ? "gpu" : "vga",
                         (op == 2) ? "write" : "read", exp_addr);

            if (!gpu_req || g_win) streak = 0;
            else if (v_win && (streak < BURST)) streak++;
            prev_op = op;
            if (g_win) g_pend = 1'b0;
            if (v_win) v_pend = 1'b0;
        end
        gpu_req = 1'b0;
        vga_req = 1'b0;
        repeat (3) @(posedge clk_ir);
        #1;

        //--------------------------------------------------------------------
        // Reset during a VGA read in flight
        //--------------------------------------------------------------------
        vga_req  = 1'b1;
        vga_addr = 18'h150;
        @(negedge clk_ir);
        chk("rst_mid vga_ready", 32'(vga_ready), 32'h1);
        @(posedge clk_ir); #1;
        vga_req  = 1'b0;
        gpu_req  = 1'b1;
        gpu_wr   = 1'b0;
        gpu_addr = 18'h3;
        chk("rst_mid pins_before", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'(P_RD));
        #2;
        rst_il = 1'b0;
        #1;
        chk("rst_mid pins", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'(P_ID));
        chk("rst_mid sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_mid sram_dq_o", 32'(sram_dq_o), 32'h0);
        chk("rst_mid gpu_ready", 32'(gpu_ready), 32'h0);
        chk("rst_mid vga_rdata", 32'(vga_rdata), 32'h0);
        @(negedge clk_ir);
        gpu_req = 1'b0;
        rst_il  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_ir); #1;
            chk($sformatf("rst_mid vga_rd_valid%0d", i), 32'(vga_rd_valid), 32'h0);
        end
        $display("reset during VGA read: checked");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/syn_sram_acc_arb.md
# syn_sram_acc_arb

Arbitrates single-word accesses to the external asynchronous frame-buffer SRAM. There are two requestors: the GPU pixel gateway (read/write) and the VGA frame fetch (read-only). It sits directly downstream of the GPU pixel gateway's SRAM access port and owns the SRAM pins. It gives VGA priority with a bounded-starvation guarantee for the GPU, inserts a bus-turnaround bubble after writes, and returns read data with a fixed latency.

## Interface
Parameters:
- ADDR_W, 18: SRAM word address width.
- DATA_W, 16: SRAM data width.
- VGA_BURST_MAX, 8: maximum consecutive VGA grants while a GPU request is waiting. Legal range is 1..255.

Ports:
- clk_ir  in  1  Clock.
- rst_il  in  1  Reset. Asynchronous, active-low.
- gpu_req  in  1  GPU access request. Held until accepted.
- gpu_wr  in  1  1 = write, 0 = read. Qualified by gpu_req.
- gpu_addr  in  ADDR_W  GPU word address.
- gpu_wdata  in  DATA_W  GPU write data.
- gpu_ready  out  1  GPU request accepted this cycle. Combinational.
- gpu_rd_valid  out  1  GPU read data valid, 1-cycle pulse.
- gpu_rdata  out  DATA_W  GPU read data.
- vga_req  in  1  VGA read request. Held until accepted.
- vga_addr  in  ADDR_W  VGA word address.
- vga_ready  out  1  VGA request accepted this cycle. Combinational.
- vga_rd_valid  out  1  VGA read data valid, 1-cycle pulse.
- vga_rdata  out  DATA_W  VGA read data.
- sram_addr  out  ADDR_W  SRAM address. Registered.
- sram_dq_o  out  DATA_W  SRAM write data. Registered.
- sram_dq_oe  out  1  Data bus output enable, active-high. Registered.
- sram_dq_i  in  DATA_W  SRAM data bus input.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low. Registered.

## Operation
- Acceptance: a request is accepted in cycle N when req and ready are both high. At most one ready is high per cycle.
- State register PS encodes the pin activity of the current cycle: IDLE, RD or WR. An acceptance in cycle N sets PS(N+1) to RD or WR. No acceptance sets PS(N+1) to IDLE.
- Eligibility in cycle N:
  - PS≠WR: any pending request is eligible.
  - PS=WR: a grant is made only if the request is a GPU write and vga_req=0. Otherwise there is no grant (turnaround bubble). Consequence: a write followed by a read always has exactly one IDLE pin cycle between them.
- Priority: VGA wins over GPU. The exception: if vga_run_cnt==VGA_BURST_MAX and the GPU is eligible, the GPU wins.
- vga_run_cnt (8 bits):
  - Increments on each VGA grant while gpu_req=1.
  - Clears to 0 on a GPU grant or whenever gpu_req=0.
  - Saturates at VGA_BURST_MAX.
- Pins in PS=RD: ce_n=0, oe_n=0, we_n=1, dq_oe=0, sram_addr = accepted address.
- Pins in PS=WR: ce_n=0, oe_n=1, we_n=0, dq_oe=1, sram_addr/sram_dq_o = accepted address/data.
- Pins in PS=IDLE: ce_n=1, oe_n=1, we_n=1, dq_oe=0. sram_addr and sram_dq_o hold their last values.
- Read return: a 1-bit owner tag is registered with each read. At the end of an RD cycle, sram_dq_i is captured into the tagged agent's rdata, and that agent's rd_valid pulses in the next cycle. rdata holds until the next read for that agent.
- Writes produce no response.

## Timing
- Reset (rst_il low, asynchronous):
  - PS=IDLE, vga_run_cnt=0.
  - sram_ce_n/oe_n/we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
  - gpu_rd_valid, vga_rd_valid = 0; gpu_rdata, vga_rdata = 0.
  - gpu_ready and vga_ready are forced to 0.
- Reset mid-operation: any in-flight read is discarded and no rd_valid is produced after reset release.
- Read latency: accept in cycle N, SRAM pins active in N+1, rd_valid/rdata in N+2.
- Throughput: 1 access/cycle for back-to-back reads, back-to-back writes, and read→write. Write→read costs 1 extra cycle.
- Simultaneous requests:
  - Without the starvation condition, VGA is served.
  - With continuous vga_req and gpu_req, the GPU is granted at least once every VGA_BURST_MAX+1 grants.
- Requests may change only after acceptance. Behaviour for requests withdrawn before acceptance is undefined.

## Test plan
- Single GPU write to 0x00010 with data 0xBEEF, then a GPU read of 0x00010 with the SRAM model returning 0xBEEF. Required:
  - Write pins: we_n=0, dq_oe=1 for exactly 1 cycle.
  - Then one IDLE cycle.
  - Read pins: oe_n=0.
  - gpu_rd_valid pulses 2 cycles after read acceptance with gpu_rdata=0xBEEF.
- vga_req held for 20 cycles on incrementing addresses 0x00100 upward, gpu_req (read) held, VGA_BURST_MAX=8. Required: grant pattern of 8 VGA, 1 GPU, repeating. vga_rd_valid count equals the VGA grant count, with addresses returned in order.
- GPU write accepted while vga_req=1. Required:
  - Next cycle has no grant and PS=IDLE.
  - The VGA read is accepted the following cycle.
  - No cycle has both we_n=0 and oe_n=0.
- 4 back-to-back GPU writes, 0x00000..0x00003. Required: 4 consecutive WR pin cycles and no bubbles.
- Assert rst_il low the cycle after a VGA read acceptance. Required: all pins return to reset values immediately, and vga_rd_valid stays 0 after reset release.
